// File: rtl/opl3_timers.sv
// OPL3 Timer 1 / Timer 2 block: decodes bank-0 registers 0x02-0x04 from the
// register-write stream and produces the status byte and the active-low IRQ.
package opl3_pkg;
  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;
endpackage

// One timer: prescaler, 8-bit up-counter with TLV reload, and overflow flag.
module opl3_timer_ch #(
  parameter int TICK_CYCLES = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tlv_we_i,
  input  logic [7:0] tlv_i,
  input  logic       ctl_we_i,
  input  logic       st_i,
  input  logic       mt_i,
  input  logic       flag_clr_i,
  output logic       flag_o
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);

  logic [7:0]    tlv_q, tlv_d, cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          st_q, st_d, mt_q, mt_d, flag_q, flag_d;
  logic          tick, ovf;

  assign tick = st_q && (presc_q == PMAX);
  assign ovf  = tick && (cnt_q == 8'hFF);

  always_comb begin
    tlv_d   = tlv_we_i ? tlv_i : tlv_q;
    st_d    = ctl_we_i ? st_i : st_q;
    mt_d    = ctl_we_i ? mt_i : mt_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    // Only a 0->1 start reloads; rewriting ST=1 leaves the running count alone.
    if (ctl_we_i && st_i && !st_q) begin
      cnt_d   = tlv_q;
      presc_d = '0;
    end else if (st_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) cnt_d = ovf ? tlv_q : cnt_q + 8'd1;
    end
    // Set has priority over the IRQ-reset clear in the same cycle.
    flag_d = flag_clr_i ? 1'b0 : flag_q;
    if (ovf && !mt_q) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlv_q   <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      st_q    <= 1'b0;
      mt_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      tlv_q   <= tlv_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      st_q    <= st_d;
      mt_q    <= mt_d;
      flag_q  <= flag_d;
    end
  end

  assign flag_o = flag_q;
endmodule

module opl3_timers #(
  parameter int TIMER1_TICK_CYCLES = 4000,
  parameter int TIMER2_TICK_CYCLES = 16000
) (
  input  logic                   clk,
  input  logic                   ic_n,
  input  opl3_pkg::opl3_reg_wr_t opl3_reg_wr,
  output logic [7:0]             status,
  output logic                   irq_n
);
  logic       dec, ctl_we, irq_clr;
  logic [1:0] flag;
  logic [7:0] status_q, status_d;
  logic       irq_n_q, irq_n_d;
  logic       unused_bits;

  assign dec     = opl3_reg_wr.valid && !opl3_reg_wr.bank_num;
  assign ctl_we  = dec && (opl3_reg_wr.address == 8'h04) && !opl3_reg_wr.data[7];
  assign irq_clr = dec && (opl3_reg_wr.address == 8'h04) &&  opl3_reg_wr.data[7];
  assign unused_bits = ^opl3_reg_wr.data[4:2];

  // Channel g: TLV at 0x02+g, ST at data[g], MT at data[6-g].
  for (genvar g = 0; g < 2; g++) begin : g_tmr
    localparam int TICK = (g == 0) ? TIMER1_TICK_CYCLES : TIMER2_TICK_CYCLES;
    opl3_timer_ch #(.TICK_CYCLES(TICK)) u_ch (
      .clk        (clk),
      .rst_n      (ic_n),
      .tlv_we_i   (dec && (opl3_reg_wr.address == 8'(2 + g))),
      .tlv_i      (opl3_reg_wr.data),
      .ctl_we_i   (ctl_we),
      .st_i       (opl3_reg_wr.data[g]),
      .mt_i       (opl3_reg_wr.data[6-g]),
      .flag_clr_i (irq_clr),
      .flag_o     (flag[g])
    );
  end

  assign status_d = {flag[0] | flag[1], flag[0], flag[1], 5'b0};
  assign irq_n_d  = ~(flag[0] | flag[1]);

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      status_q <= 8'h00;
      irq_n_q  <= 1'b1;
    end else begin
      status_q <= status_d;
      irq_n_q  <= irq_n_d;
    end
  end

  assign status = status_q;
  assign irq_n  = irq_n_q;
endmodule

// File: tb/tb_opl3_timers.sv
// Scoreboard bench for opl3_timers: stimulus queues expected status/irq_n per
// cycle, a monitor pops and compares on the falling clock edge.
module tb_opl3_timers;
  logic clk = 1'b0;
  logic ic_n = 1'b0;
  opl3_pkg::opl3_reg_wr_t wr_s = '0;
  logic [7:0] st0, st1;
  logic       irq0, irq1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: tick 4/4, u1: tick 2/2 for the simultaneous-event case.
  opl3_timers #(.TIMER1_TICK_CYCLES(4), .TIMER2_TICK_CYCLES(4)) u0 (
    .clk(clk), .ic_n(ic_n), .opl3_reg_wr(wr_s), .status(st0), .irq_n(irq0));
  opl3_timers #(.TIMER1_TICK_CYCLES(2), .TIMER2_TICK_CYCLES(2)) u1 (
    .clk(clk), .ic_n(ic_n), .opl3_reg_wr(wr_s), .status(st1), .irq_n(irq1));

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] st;
    logic       irqn;
    string      name;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [7:0] act_st;
  logic       act_irq;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act_st  = (e.sel != 0) ? st1 : st0;
      act_irq = (e.sel != 0) ? irq1 : irq0;
      checks++;
      if (e.cyc != cyc || act_st !== e.st || act_irq !== e.irqn) begin
        errors++;
        $display("FAIL %s @cyc %0d (due %0d): status=%h irq_n=%b, expected status=%h irq_n=%b",
                 e.name, cyc, e.cyc, act_st, act_irq, e.st, e.irqn);
      end
    end
  end

  task automatic expect_at(input int c, input int s, input logic [7:0] st, input string nm);
    exp_t x;
    x.cyc = c; x.sel = s; x.st = st; x.irqn = ~st[7]; x.name = nm;
    q.push_back(x);
  endtask

  task automatic wr(input logic v, input logic b, input logic [7:0] a,
                    input logic [7:0] d, output int eg);
    @(negedge clk);
    wr_s.valid = v; wr_s.bank_num = b; wr_s.address = a; wr_s.data = d;
    @(posedge clk); #1;
    eg = cyc;
    wr_s = '0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    ic_n = 1'b0;
    expect_at(cyc + 1, 0, 8'h00, nm);
    expect_at(cyc + 1, 1, 8'h00, nm);
    repeat (3) @(negedge clk);
    ic_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int e0, e1, base, t;
    repeat (3) @(posedge clk);
    @(negedge clk) ic_n = 1'b1;
    @(posedge clk); #1;

    // Idle after reset
    base = cyc;
    for (int i = 1; i <= 1000; i++) expect_at(base + i, 0, 8'h00, "idle");
    wait_to(base + 1000);

    // Timer 1, TLV=FE, TICK=4: overflow every 8 cycles
    wr(1, 0, 8'h02, 8'hFE, e1);
    wr(1, 0, 8'h04, 8'h01, e0);
    expect_at(e0 + 8,  0, 8'h00, "t1_before_ovf");
    expect_at(e0 + 9,  0, 8'hC0, "t1_first_ovf");
    expect_at(e0 + 10, 0, 8'hC0, "t1_held");
    expect_at(e0 + 11, 0, 8'h00, "t1_irq_reset");
    expect_at(e0 + 16, 0, 8'h00, "t1_before_reload_ovf");
    expect_at(e0 + 17, 0, 8'hC0, "t1_reload_ovf");
    wait_to(e0 + 9);
    wr(1, 0, 8'h04, 8'h80, e1);
    wait_to(e0 + 20);
    do_reset("reset_clears_t1");

    // Timer 2 masked, then unmasked without restart
    wr(1, 0, 8'h03, 8'hFF, e1);
    wr(1, 0, 8'h04, 8'h22, e0);
    expect_at(e0 + 50,  0, 8'h00, "t2_masked_50");
    expect_at(e0 + 100, 0, 8'h00, "t2_masked_100");
    wait_to(e0 + 100);
    wr(1, 0, 8'h04, 8'h02, e1);
    t = e0 + 4 * ((e1 - e0) / 4 + 1);
    expect_at(t,     0, 8'h00, "t2_before_unmasked_ovf");
    expect_at(t + 1, 0, 8'hA0, "t2_unmasked_ovf");
    wait_to(t + 5);
    do_reset("reset_clears_t2");

    // Ignored writes: bank 1, bad address, valid=0
    wr(1, 0, 8'h02, 8'hFF, e1);
    wr(1, 0, 8'h03, 8'hFF, e1);
    wr(1, 1, 8'h04, 8'h03, e1);
    wr(1, 0, 8'h05, 8'h03, e1);
    wr(0, 0, 8'h04, 8'h03, e1);
    for (int i = 5; i <= 50; i += 5) expect_at(e1 + i, 0, 8'h00, "ignored_writes");
    wait_to(e1 + 50);

    // Both timers on u1 (tick 2), TLV=FF: simultaneous overflows
    wr(1, 0, 8'h02, 8'hFF, e1);
    wr(1, 0, 8'h03, 8'hFF, e1);
    wr(1, 0, 8'h04, 8'h03, e0);
    expect_at(e0 + 2,  1, 8'h00, "both_before_ovf");
    expect_at(e0 + 3,  1, 8'hE0, "both_ovf_same_cycle");
    expect_at(e0 + 7,  1, 8'hE0, "irq_reset_vs_ovf");
    expect_at(e0 + 8,  1, 8'hE0, "irq_reset_vs_ovf_hold");
    expect_at(e0 + 10, 1, 8'h00, "irq_reset_off_ovf");
    expect_at(e0 + 11, 1, 8'hE0, "reovf_after_reset");
    wait_to(e0 + 5);
    wr(1, 0, 8'h04, 8'h80, e1);   // edge e0+6 coincides with overflow
    wait_to(e0 + 8);
    wr(1, 0, 8'h04, 8'h80, e1);   // edge e0+9 does not
    wait_to(e0 + 14);
    do_reset("reset_clears_both");

    // Timer 1 TLV=00, reset mid-count, then full-length V=0 period
    wr(1, 0, 8'h02, 8'h00, e1);
    wr(1, 0, 8'h04, 8'h01, e0);
    wait_to(e0 + 20);
    do_reset("reset_mid_count");
    base = cyc;
    for (int i = 50; i <= 1100; i += 50) expect_at(base + i, 0, 8'h00, "no_ovf_after_reset");
    wait_to(base + 1100);
    wr(1, 0, 8'h04, 8'h01, e0);
    expect_at(e0 + 1024, 0, 8'h00, "tlv0_before_ovf");
    expect_at(e0 + 1025, 0, 8'hC0, "tlv0_ovf_256_ticks");
    wait_to(e0 + 1030);

    for (int i = 0; i < 2000 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
